// File: rtl/div64x32.sv
// Sequential unsigned 64/32 restoring divider: one quotient bit per clock,
// with divide-by-zero and quotient-overflow detection up front.
module div64x32 (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [63:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        div_by_zero_o,
    output logic        overflow_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {EXC_NONE, EXC_DBZ, EXC_OVF} exc_t;

    state_t      state_q;
    exc_t        exc_q;
    logic [32:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] div_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic [31:0] quotient_q;
    logic [31:0] remainder_q;
    logic        dbz_q;
    logic        ovf_q;

    logic [33:0] shifted;
    logic [32:0] diff;
    logic        fits;
    logic [32:0] rem_d;
    logic [31:0] quo_d;

    // One restoring step: shift {R,Q} left, try subtracting D, keep it if it fits.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        fits    = (shifted >= {2'b00, div_q});
        diff    = shifted[32:0] - {1'b0, div_q};
        rem_d   = fits ? diff : shifted[32:0];
        quo_d   = {quo_q[30:0], fits};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            exc_q       <= EXC_NONE;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        div_q  <= divisor_i;
                        rem_q  <= {1'b0, dividend_i[63:32]};
                        quo_q  <= dividend_i[31:0];
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        // A high half >= divisor means the quotient cannot fit in 32 bits.
                        if (divisor_i == 32'd0) begin
                            exc_q   <= EXC_DBZ;
                            state_q <= DONE;
                        end else if (dividend_i[63:32] >= divisor_i) begin
                            exc_q   <= EXC_OVF;
                            state_q <= DONE;
                        end else begin
                            exc_q   <= EXC_NONE;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    case (exc_q)
                        EXC_DBZ: begin
                            quotient_q  <= 32'hFFFF_FFFF;
                            remainder_q <= quo_q;
                            dbz_q       <= 1'b1;
                            ovf_q       <= 1'b0;
                        end
                        EXC_OVF: begin
                            quotient_q  <= 32'hFFFF_FFFF;
                            remainder_q <= 32'h0;
                            dbz_q       <= 1'b0;
                            ovf_q       <= 1'b1;
                        end
                        default: begin
                            quotient_q  <= quo_q;
                            remainder_q <= rem_q[31:0];
                            dbz_q       <= 1'b0;
                            ovf_q       <= 1'b0;
                        end
                    endcase
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_div64x32.sv
// Self-checking bench for div64x32: directed cases plus randomized operands
// compared against a plain-arithmetic reference model.
module tb_div64x32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        divByZero;
    logic        overflow;

    int compared   = 0;
    int mismatched = 0;

    div64x32 dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
        .busy_o       (busy),
        .quotient_o   (quotient),
        .remainder_o  (remainder),
        .div_by_zero_o(divByZero),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: exceptions decided from the operands, otherwise native 64-bit / and %.
    function automatic void refModel(input logic [63:0] dvd, input logic [31:0] dvs,
                                     output logic [31:0] q, output logic [31:0] r,
                                     output logic dbz, output logic ovf, output int cycles);
        logic [63:0] q64;
        logic [63:0] r64;
        dbz = 1'b0;
        ovf = 1'b0;
        if (dvs == 32'd0) begin
            q = 32'hFFFF_FFFF;  r = dvd[31:0];  dbz = 1'b1;  cycles = 1;
        end else if (dvd[63:32] >= dvs) begin
            q = 32'hFFFF_FFFF;  r = 32'h0;      ovf = 1'b1;  cycles = 1;
        end else begin
            q64 = dvd / {32'h0, dvs};
            r64 = dvd % {32'h0, dvs};
            q = q64[31:0];  r = r64[31:0];  cycles = 33;
        end
    endfunction

    // Starts one division, optionally pulses start again after run cycle disturbAt,
    // measures the busy window and checks the delivered results.
    task automatic applyStimulus(input logic [63:0] dvd, input logic [31:0] dvs,
                                 input int disturbAt, input string tag);
        logic [31:0] expQ, expR;
        logic        expDbz, expOvf;
        int          expCycles;
        int          busyCycles;
        refModel(dvd, dvs, expQ, expR, expDbz, expOvf, expCycles);
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = $urandom;
        busyCycles = 0;
        while (busy && busyCycles < 100) begin
            if (busyCycles == disturbAt) begin
                start    = 1'b1;
                dividend = {$urandom, $urandom};
                divisor  = $urandom_range(1, 5);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            busyCycles++;
        end
        start = 1'b0;
        checkOutput({tag, ".busyCycles"}, 64'(busyCycles), 64'(expCycles));
        checkOutput({tag, ".quotient"},   {32'h0, quotient},  {32'h0, expQ});
        checkOutput({tag, ".remainder"},  {32'h0, remainder}, {32'h0, expR});
        checkOutput({tag, ".flags"},      {62'h0, divByZero, overflow}, {62'h0, expDbz, expOvf});
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] product;
        logic [31:0] hi, lo, dvs;
        int          n;
        int          mode;

        reset    = 1'b1;
        start    = 1'b1;
        dividend = 64'd100;
        divisor  = 32'd7;

        // Reset must dominate a concurrently asserted start.
        repeat (4) begin
            @(posedge clk);
            #1;
            checkOutput("reset.ctrl", {61'h0, busy, divByZero, overflow}, 64'h0);
            checkOutput("reset.data", {quotient, remainder}, 64'h0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("reset.firstAccept", {63'h0, busy}, 64'h1);
        n = 1;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("reset.firstBusy", 64'(n), 64'd34);
        checkOutput("reset.firstResult", {quotient, remainder}, {32'd14, 32'd2});

        applyStimulus(64'd100, 32'd7, -1, "basic");
        applyStimulus(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, -1, "invMax");
        product = 64'h1234_5678 * 64'h9ABC_DEF0;
        applyStimulus(product, 32'h9ABC_DEF0, -1, "invProdA");
        applyStimulus(product, 32'h1234_5678, -1, "invProdB");
        applyStimulus(64'h0000_0005_0000_0009, 32'h0, -1, "divZero");
        applyStimulus(64'h0000_0001_0000_0000, 32'h1, -1, "ovf");
        applyStimulus(64'h0000_0000_FFFF_FFFF, 32'h1, -1, "maxQuot");
        applyStimulus(64'h0000_0006_0000_0000, 32'h6, -1, "ovfEqual");
        applyStimulus(64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, -1, "maxRem");
        applyStimulus(64'd100, 32'd7, 10, "startIgnored");

        // Held start: the next acceptance lands exactly 34 edges after the previous one.
        @(negedge clk);
        dividend = 64'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        n++;
        start = 1'b0;
        checkOutput("heldStart.period", 64'(n), 64'd34);
        checkOutput("heldStart.reaccept", {63'h0, busy}, 64'h1);
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("heldStart.result", {quotient, remainder}, {32'd14, 32'd2});

        // Reset mid-run discards the work in progress and clears the held results.
        applyStimulus(64'h0000_0005_0000_0009, 32'h0, -1, "preReset");
        @(negedge clk);
        dividend = 64'h0000_0000_1234_5678;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("midReset.ctrl", {61'h0, busy, divByZero, overflow}, 64'h0);
        checkOutput("midReset.data", {quotient, remainder}, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midReset.stayIdle", {63'h0, busy}, 64'h0);
        applyStimulus(64'd100, 32'd7, -1, "postReset");

        for (int i = 0; i < 30; i++) begin
            mode = $urandom_range(0, 9);
            lo   = $urandom;
            if (mode == 0) begin
                hi  = $urandom;
                dvs = 32'h0;
            end else if (mode == 1) begin
                hi  = $urandom | 32'h1;
                dvs = ($urandom % hi) + 32'd1;
            end else if (mode == 2) begin
                dvs = $urandom_range(1, 15);
                hi  = $urandom % dvs;
            end else begin
                dvs = $urandom | 32'h1;
                hi  = $urandom % dvs;
            end
            applyStimulus({hi, lo}, dvs, (mode == 3) ? 5 : -1, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/div64x32.md
# div64x32

Sequential unsigned divider: 64-bit dividend by 32-bit divisor, yielding a 32-bit quotient and 32-bit remainder. It is the inverse of `mult32x32`. A 64-bit product from the multiplier divided by either 32-bit operand returns the other operand with remainder 0. It uses the same `start`/`busy` handshake as the multiplier, so one controller can drive both blocks. It computes one restoring-division step per clock and flags divide-by-zero and quotient overflow.

## Interface
- No parameters; all widths fixed.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `start` input 1: request a division; sampled only in IDLE.
- `dividend` input 64: unsigned dividend; sampled on the accepting edge only.
- `divisor` input 32: unsigned divisor; sampled on the accepting edge only.
- `busy` output 1: high from the cycle after acceptance until results are valid.
- `quotient` output 32: registered result; holds until the next completion.
- `remainder` output 32: registered result; holds until the next completion.
- `div_by_zero` output 1: registered; set at completion when divisor == 0.
- `overflow` output 1: registered; set at completion when divisor != 0 and dividend[63:32] >= divisor.

## Operation
- States: IDLE, RUN, DONE.
- Internal registers: 33-bit partial remainder `R`, 32-bit shift register `Q`, 32-bit divisor copy `D`, 5-bit step counter, 2-bit exception code.
- IDLE, on `start`=1:
  - Latch `D` = divisor, `R` = {1'b0, dividend[63:32]}, `Q` = dividend[31:0]; clear the counter.
  - If divisor == 0: exception = DBZ, go to DONE.
  - Else if dividend[63:32] >= divisor: exception = OVF, go to DONE.
  - Else: exception = NONE, go to RUN.
- IDLE, `start`=0: stay in IDLE; outputs hold.
- RUN, one step per cycle:
  - Form {R,Q} shifted left by 1; bit Q[31] enters R[0].
  - If the shifted R >= {1'b0,D}: R = shifted R − D and new Q[0] = 1; else new Q[0] = 0.
  - Increment the counter. On the step with counter == 31, go to DONE. Exactly 32 steps.
- DONE, one cycle, then IDLE:
  - NONE: `quotient` = Q, `remainder` = R[31:0], both flags 0.
  - DBZ: `quotient` = 32'hFFFF_FFFF, `remainder` = dividend[31:0] as latched, `div_by_zero` = 1, `overflow` = 0.
  - OVF: `quotient` = 32'hFFFF_FFFF, `remainder` = 32'h0, `overflow` = 1, `div_by_zero` = 0.
- Invariant in RUN: R < D before each shift, so R never exceeds 33 bits.
- `start` in RUN or DONE is ignored. It does not queue or restart.
- Output registers and flags change only on the DONE → IDLE edge and on reset.

## Timing
- Reset values: `busy`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, `overflow`=0, state IDLE, counter 0.
- Edge E0: IDLE samples `start`=1. `busy`=1 after E0.
- Normal division:
  - RUN steps occur on edges E1..E32; DONE on E33.
  - Results valid and `busy`=0 after E33, so `busy` is high 33 cycles.
  - The earliest next acceptance is edge E34.
- Exception path: DONE on E1. Results and flags valid and `busy`=0 after E1, so `busy` is high 1 cycle.
- `start` held high continuously: re-accepted on the first IDLE edge after completion. Back-to-back throughput is 34 cycles per normal division.
- `reset`=1 on any edge wins over every other event, including mid-RUN and coincident with `start`. All state and outputs return to reset values after that edge, and the partial result is discarded.
- Operands may change freely after E0 without affecting the result.

## Test plan
- Reset: hold `reset` 4 cycles with `start`=1 → all outputs 0 and `busy`=0 throughout; after release, `busy` rises the cycle after the first `start` edge.
- Basic: dividend 64'd100, divisor 32'd7 → `busy` high exactly 33 cycles, then `quotient`=14, `remainder`=2, flags 0.
- Multiplier inverse: dividend 64'hFFFF_FFFE_0000_0001, divisor 32'hFFFF_FFFF → `quotient`=32'hFFFF_FFFF, `remainder`=0. Also: dividend = product of 32'h1234_5678 × 32'h9ABC_DEF0, divisor 32'h9ABC_DEF0 → `quotient`=32'h1234_5678, `remainder`=0.
- Divide by zero: dividend 64'h0000_0005_0000_0009, divisor 0 → `busy` high 1 cycle; `div_by_zero`=1, `quotient`=32'hFFFF_FFFF, `remainder`=32'h9.
- Overflow: dividend 64'h0000_0001_0000_0000, divisor 1 → `overflow`=1, `quotient`=32'hFFFF_FFFF, `remainder`=0, `busy` high 1 cycle.
  - Follow with 64'h0000_0000_FFFF_FFFF / 1 → `quotient`=32'hFFFF_FFFF, `remainder`=0, flags 0.
- Disturbance: pulse `start` with new operands at cycle 10 of a run → ignored, original result is delivered. Assert `reset` at cycle 20 of a run → outputs 0 and `busy`=0 the next cycle; a subsequent 100/7 returns 14 r 2.
